// File: rtl/link_mm_bridge_if.sv
// link_mm_bridge_if: host register-bus and link decoder signals of the bridge.
// slave modport is the bridge's view; master is the host/decoder side.
interface link_mm_bridge_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] iAVS_ADDR;
  logic              iAVS_WR;
  logic              iAVS_RD;
  logic [63:0]       iAVS_WR_DATA;
  logic              oAVS_WAIT;
  logic [63:0]       oAVS_RD_DATA;
  logic              oAVS_RD_DATA_V;
  logic [ADDR_W-1:0] oMM_ADDR;
  logic [63:0]       oMM_WR_DATA;
  logic              oMM_WR_EN;
  logic              oMM_RD_EN;
  logic [63:0]       iMM_RD_DATA;
  logic              iMM_RD_DATA_V;
  logic [15:0]       oTIMEOUT_CNT;
  logic [1:0]        oERR_STICKY;

  modport slave (
    input  iAVS_ADDR, iAVS_WR, iAVS_RD, iAVS_WR_DATA, iMM_RD_DATA, iMM_RD_DATA_V,
    output oAVS_WAIT, oAVS_RD_DATA, oAVS_RD_DATA_V, oMM_ADDR, oMM_WR_DATA,
           oMM_WR_EN, oMM_RD_EN, oTIMEOUT_CNT, oERR_STICKY
  );

  modport master (
    output iAVS_ADDR, iAVS_WR, iAVS_RD, iAVS_WR_DATA, iMM_RD_DATA, iMM_RD_DATA_V,
    input  oAVS_WAIT, oAVS_RD_DATA, oAVS_RD_DATA_V, oMM_ADDR, oMM_WR_DATA,
           oMM_WR_EN, oMM_RD_EN, oTIMEOUT_CNT, oERR_STICKY
  );
endinterface

// File: rtl/link_mm_bridge.sv
// link_mm_bridge: host register bus to link address decoder bridge.
// Writes are posted (one per cycle); reads stall the host until the decoder answers.
// Optional read-response timeout: define LINK_MM_BRIDGE_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a host request, waitrequest low
// RD_WAIT | read strobe issued, waiting for decoder response, waitrequest high
module link_mm_bridge #(
  parameter int ADDR_W         = 17,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  link_mm_bridge_if.slave  bus
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t state_q, state_d;
  logic   acc_wr, acc_rd, rsp_hit, to_hit, stray, both;
  logic   to_reached;

`ifdef LINK_MM_BRIDGE_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // Wait counter: zero on read acceptance, counts every RD_WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_cnt <= '0;
    else if (acc_rd)            wait_cnt <= '0;
    else if (state_q == RD_WAIT) wait_cnt <= wait_cnt + 16'd1;
  end

  assign to_reached = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Saturating timeout event counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   bus.oTIMEOUT_CNT <= '0;
    else if (to_hit && bus.oTIMEOUT_CNT != 16'hFFFF) bus.oTIMEOUT_CNT <= bus.oTIMEOUT_CNT + 16'd1;
  end
`else
  assign to_reached       = 1'b0;
  assign bus.oTIMEOUT_CNT = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and transfer decode; a write always wins over a same-cycle read.
  always_comb begin
    state_d = state_q;
    acc_wr  = 1'b0;
    acc_rd  = 1'b0;
    rsp_hit = 1'b0;
    to_hit  = 1'b0;
    stray   = 1'b0;
    both    = 1'b0;
    case (state_q)
      IDLE: begin
        stray = bus.iMM_RD_DATA_V;
        if (bus.iAVS_WR) begin
          acc_wr = 1'b1;
          both   = bus.iAVS_RD;
        end else if (bus.iAVS_RD) begin
          acc_rd  = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.iMM_RD_DATA_V) begin
          rsp_hit = 1'b1;
          state_d = IDLE;
        end else if (to_reached) begin
          to_hit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.oAVS_WAIT = (state_q == RD_WAIT);

  // Registered strobes, address/data capture, read return and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.oMM_WR_EN      <= 1'b0;
      bus.oMM_RD_EN      <= 1'b0;
      bus.oMM_ADDR       <= '0;
      bus.oMM_WR_DATA    <= '0;
      bus.oAVS_RD_DATA   <= '0;
      bus.oAVS_RD_DATA_V <= 1'b0;
      bus.oERR_STICKY    <= '0;
    end else begin
      bus.oMM_WR_EN      <= acc_wr;
      bus.oMM_RD_EN      <= acc_rd;
      bus.oAVS_RD_DATA_V <= rsp_hit | to_hit;
      if (acc_wr || acc_rd) begin
        bus.oMM_ADDR    <= bus.iAVS_ADDR;
        bus.oMM_WR_DATA <= bus.iAVS_WR_DATA;
      end
      if (rsp_hit)     bus.oAVS_RD_DATA <= bus.iMM_RD_DATA;
      else if (to_hit) bus.oAVS_RD_DATA <= {32'hDEAD_BEEF, 32'(bus.oMM_ADDR)};
      if (stray) bus.oERR_STICKY[0] <= 1'b1;
      if (both)  bus.oERR_STICKY[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_link_mm_bridge.sv
// tb_link_mm_bridge: directed scenarios plus randomized traffic against a
// transaction-level reference model of the bridge.
module tb_link_mm_bridge;
  localparam int AW = 17;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  link_mm_bridge_if #(.ADDR_W(AW)) bus ();

  link_mm_bridge #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending-read flag plus expected registered outputs.
  bit          m_busy = 0;
  int          m_waited = 0;
  bit          m_wr_en = 0, m_rd_en = 0, m_rdv = 0;
  logic [AW-1:0] m_addr = '0;
  logic [63:0] m_wdata = '0, m_rdata = '0;
  int          m_tcnt = 0;
  logic [1:0]  m_err = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_waited = 0; m_wr_en = 0; m_rd_en = 0; m_rdv = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_tcnt = 0; m_err = '0;
    end else begin
      m_wr_en = 0; m_rd_en = 0; m_rdv = 0;
      if (!m_busy) begin
        if (bus.iMM_RD_DATA_V) m_err[0] = 1'b1;
        if (bus.iAVS_WR || bus.iAVS_RD) begin
          m_addr  = bus.iAVS_ADDR;
          m_wdata = bus.iAVS_WR_DATA;
        end
        if (bus.iAVS_WR) begin
          m_wr_en = 1;
          if (bus.iAVS_RD) m_err[1] = 1'b1;
        end else if (bus.iAVS_RD) begin
          m_rd_en = 1; m_busy = 1; m_waited = 0;
        end
      end else if (bus.iMM_RD_DATA_V) begin
        m_rdata = bus.iMM_RD_DATA; m_rdv = 1; m_busy = 0;
      end
`ifdef LINK_MM_BRIDGE_TIMEOUT_EN
      else if (m_waited == TO - 1) begin
        m_rdata = {32'hDEADBEEF, 32'(m_addr)};
        m_rdv = 1; m_busy = 0;
        if (m_tcnt < 65535) m_tcnt++;
      end else m_waited++;
`endif
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("m_wait",  64'(bus.oAVS_WAIT), 64'(m_busy));
    chk("m_wr_en", 64'(bus.oMM_WR_EN), 64'(m_wr_en));
    chk("m_rd_en", 64'(bus.oMM_RD_EN), 64'(m_rd_en));
    chk("m_addr",  64'(bus.oMM_ADDR), 64'(m_addr));
    chk("m_wdata", bus.oMM_WR_DATA, m_wdata);
    chk("m_rdv",   64'(bus.oAVS_RD_DATA_V), 64'(m_rdv));
    chk("m_rdata", bus.oAVS_RD_DATA, m_rdata);
    chk("m_tcnt",  64'(bus.oTIMEOUT_CNT), 64'(m_tcnt));
    chk("m_err",   64'(bus.oERR_STICKY), 64'(m_err));
  end

  task automatic idle_inputs();
    bus.iAVS_ADDR = '0; bus.iAVS_WR = 0; bus.iAVS_RD = 0; bus.iAVS_WR_DATA = '0;
    bus.iMM_RD_DATA = '0; bus.iMM_RD_DATA_V = 0;
  endtask

  task automatic chk_reset_vals(input string ph);
    chk({ph, "_wait"},  64'(bus.oAVS_WAIT), 64'd0);
    chk({ph, "_rdata"}, bus.oAVS_RD_DATA, 64'd0);
    chk({ph, "_rdv"},   64'(bus.oAVS_RD_DATA_V), 64'd0);
    chk({ph, "_addr"},  64'(bus.oMM_ADDR), 64'd0);
    chk({ph, "_wdata"}, bus.oMM_WR_DATA, 64'd0);
    chk({ph, "_wr_en"}, 64'(bus.oMM_WR_EN), 64'd0);
    chk({ph, "_rd_en"}, 64'(bus.oMM_RD_EN), 64'd0);
    chk({ph, "_tcnt"},  64'(bus.oTIMEOUT_CNT), 64'd0);
    chk({ph, "_err"},   64'(bus.oERR_STICKY), 64'd0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    step(); #2; rst_n = 0; #1;
    chk_reset_vals("rst_pulse");
    step(); rst_n = 1;
  endtask

  logic [63:0] wd [8];
  int          hit;
  bit          wait_seen;

  initial begin
    idle_inputs();
    #2;
    chk_reset_vals("por");
    step(); step(); rst_n = 1;

    // single write
    step(); bus.iAVS_WR = 1; bus.iAVS_ADDR = 17'h0_2010; bus.iAVS_WR_DATA = 64'h1234;
    @(negedge clk); chk("wr_c0_wait", 64'(bus.oAVS_WAIT), 64'd0);
    step(); idle_inputs();
    @(negedge clk);
    chk("wr_c1_en",   64'(bus.oMM_WR_EN), 64'd1);
    chk("wr_c1_addr", 64'(bus.oMM_ADDR), 64'h2010);
    chk("wr_c1_data", bus.oMM_WR_DATA, 64'h1234);
    chk("wr_c1_wait", 64'(bus.oAVS_WAIT), 64'd0);
    step(); @(negedge clk);
    chk("wr_c2_en",   64'(bus.oMM_WR_EN), 64'd0);
    chk("wr_c2_addr", 64'(bus.oMM_ADDR), 64'h2010);

    // read answered at cycle +5
    step(); bus.iAVS_RD = 1; bus.iAVS_ADDR = 17'h0_4008;
    @(negedge clk); chk("rd_c0_wait", 64'(bus.oAVS_WAIT), 64'd0);
    for (int c = 1; c <= 6; c++) begin
      step();
      bus.iAVS_RD = 0;
      bus.iMM_RD_DATA_V = (c == 5);
      bus.iMM_RD_DATA   = (c == 5) ? 64'hCAFE : 64'h0;
      @(negedge clk);
      chk("rd_wait", 64'(bus.oAVS_WAIT), 64'(c <= 5));
      chk("rd_en",   64'(bus.oMM_RD_EN), 64'(c == 1));
      chk("rd_v",    64'(bus.oAVS_RD_DATA_V), 64'(c == 6));
    end
    chk("rd_data", bus.oAVS_RD_DATA, 64'hCAFE);
    chk("rd_addr", 64'(bus.oMM_ADDR), 64'h4008);
    idle_inputs();

    // simultaneous write and read
    step(); bus.iAVS_WR = 1; bus.iAVS_RD = 1; bus.iAVS_ADDR = 17'h0_0ABC; bus.iAVS_WR_DATA = 64'h77;
    step(); idle_inputs();
    @(negedge clk);
    chk("both_wr_en", 64'(bus.oMM_WR_EN), 64'd1);
    chk("both_rd_en", 64'(bus.oMM_RD_EN), 64'd0);
    step(); @(negedge clk);
    chk("both_rd_en2", 64'(bus.oMM_RD_EN), 64'd0);
    chk("both_wait",   64'(bus.oAVS_WAIT), 64'd0);
    chk("both_err",    64'(bus.oERR_STICKY), 64'd2);

    // eight back-to-back writes
    wait_seen = 0;
    for (int c = 0; c <= 9; c++) begin
      step();
      if (c < 8) begin
        wd[c] = {$urandom, $urandom};
        bus.iAVS_WR = 1; bus.iAVS_ADDR = AW'(17'h100 + c); bus.iAVS_WR_DATA = wd[c];
      end else idle_inputs();
      @(negedge clk);
      if (bus.oAVS_WAIT) wait_seen = 1;
      if (c >= 1 && c <= 8) begin
        chk("b2b_en",   64'(bus.oMM_WR_EN), 64'd1);
        chk("b2b_addr", 64'(bus.oMM_ADDR), 64'(17'h100 + c - 1));
        chk("b2b_data", bus.oMM_WR_DATA, wd[c-1]);
      end
    end
    chk("b2b_en_end", 64'(bus.oMM_WR_EN), 64'd0);
    chk("b2b_no_wait", 64'(wait_seen), 64'd0);

    // reset two cycles into RD_WAIT
    step(); bus.iAVS_RD = 1; bus.iAVS_ADDR = 17'h0_0123;
    step(); idle_inputs();
    step(); #3;
    chk("rstrd_wait_pre", 64'(bus.oAVS_WAIT), 64'd1);
    rst_n = 0; #1;
    chk_reset_vals("rstrd");
    step(); step(); rst_n = 1;
    bus.iMM_RD_DATA_V = 1; bus.iMM_RD_DATA = 64'h5A5A;
    step(); idle_inputs();
    hit = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); if (bus.oAVS_RD_DATA_V) hit++;
      step();
    end
    chk("rstrd_no_rdv", 64'(hit), 64'd0);
    chk("rstrd_err", 64'(bus.oERR_STICKY), 64'd1);

    pulse_reset();
`ifdef LINK_MM_BRIDGE_TIMEOUT_EN
    // timeout then a late response
    step(); bus.iAVS_RD = 1; bus.iAVS_ADDR = 17'h1_FFFF;
    step(); idle_inputs();
    hit = -1;
    for (int c = 1; c <= 40 && hit < 0; c++) begin
      @(negedge clk);
      if (bus.oAVS_RD_DATA_V) hit = c;
      else step();
    end
    chk("to_cycle", 64'(hit), 64'd17);
    chk("to_data", bus.oAVS_RD_DATA, 64'hDEAD_BEEF_0001_FFFF);
    chk("to_cnt",  64'(bus.oTIMEOUT_CNT), 64'd1);
    step(); bus.iMM_RD_DATA_V = 1; bus.iMM_RD_DATA = 64'h99;
    step(); idle_inputs();
    @(negedge clk);
    chk("to_late_rdv", 64'(bus.oAVS_RD_DATA_V), 64'd0);
    chk("to_late_err", 64'(bus.oERR_STICKY), 64'd1);
`else
    // without timeout the bridge waits indefinitely
    step(); bus.iAVS_RD = 1; bus.iAVS_ADDR = 17'h1_FFFF;
    step(); idle_inputs();
    repeat (30) step();
    @(negedge clk);
    chk("nto_wait", 64'(bus.oAVS_WAIT), 64'd1);
    chk("nto_cnt",  64'(bus.oTIMEOUT_CNT), 64'd0);
    step(); bus.iMM_RD_DATA_V = 1; bus.iMM_RD_DATA = 64'h55;
    step(); idle_inputs();
    @(negedge clk);
    chk("nto_rdv",  64'(bus.oAVS_RD_DATA_V), 64'd1);
    chk("nto_data", bus.oAVS_RD_DATA, 64'h55);
`endif

    // randomized traffic, checked by the model every cycle
    pulse_reset();
    for (int c = 0; c < 500; c++) begin
      step();
      bus.iAVS_WR      = ($urandom % 4) == 0;
      bus.iAVS_RD      = ($urandom % 4) == 0;
      bus.iAVS_ADDR    = AW'($urandom);
      bus.iAVS_WR_DATA = {$urandom, $urandom};
      bus.iMM_RD_DATA  = {$urandom, $urandom};
      bus.iMM_RD_DATA_V = m_busy ? (($urandom % 6) == 0) : (($urandom % 40) == 0);
    end
    step(); idle_inputs();
    for (int c = 0; c < 100 && m_busy; c++) begin
      bus.iMM_RD_DATA_V = 1; bus.iMM_RD_DATA = {$urandom, $urandom};
      step(); idle_inputs();
    end
    chk("drain_idle", 64'(m_busy), 64'd0);
    repeat (3) step();
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
